// File: rtl/core_ctrl_if.sv
// Memory request handshake between the core control FSM
// and the unified memory port.
interface core_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb,
// drives datapath strobes and counts retired instructions.
module core_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  core_ctrl_if.master      mem,
  input  logic [3:0]       inst_type,
  input  logic [4:0]       rd,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } st_e;

  localparam logic [3:0] T_LOAD  = 4'd0;
  localparam logic [3:0] T_IMM   = 4'd1;
  localparam logic [3:0] T_STORE = 4'd2;
  localparam logic [3:0] T_REG   = 4'd3;
  localparam logic [3:0] T_LUI   = 4'd4;
  localparam logic [3:0] T_AUIPC = 4'd5;
  localparam logic [3:0] T_BR    = 4'd6;
  localparam logic [3:0] T_JALR  = 4'd7;
  localparam logic [3:0] T_JAL   = 4'd8;

  st_e              state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // State and retire counter registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next state and per-state datapath strobes; reset masks strobes.
  always_comb begin
    state_d      = state_q;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_we        = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    unique case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (inst_type > T_JAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        unique case (inst_type)
          T_REG: begin
            alu_b_sel = 1'b0;
          end
          T_BR: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          T_AUIPC, T_JAL: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          T_LOAD, T_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          default: begin
            alu_b_sel = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = (inst_type == T_STORE);
        if (mem.mem_ack) begin
          if (inst_type == T_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = (rd != 5'd0);
        pc_we   = 1'b1;
        state_d = S_FETCH;
        unique case (inst_type)
          T_LOAD:  wb_sel = 2'd1;
          T_LUI:   wb_sel = 2'd3;
          T_JAL: begin
            wb_sel = 2'd2;
            pc_sel = 2'd1;
          end
          T_JALR: begin
            wb_sel = 2'd2;
            pc_sel = 2'd2;
          end
          default: wb_sel = 2'd0;
        endcase
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (!rst_n) begin
      mem.mem_req  = 1'b0;
      mem.mem_we   = 1'b0;
      mem.addr_sel = 1'b0;
      ir_we        = 1'b0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
    end
  end

  // One retirement per PC write; wraps naturally.
  always_comb begin
    instret_d = instret_q;
    if (pc_we) instret_d = instret_q + CNT_W'(1);
  end

  assign trap    = (state_q == S_TRAP);
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized scoreboard bench for core_ctrl: phase-level model
// builds expected per-cycle outputs, monitor compares them.
module tb_core_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] inst_type;
  logic [4:0] rd;
  logic       branch_taken;
  logic       ir_we, alu_a_sel, alu_b_sel, reg_we, pc_we, trap;
  logic [1:0] wb_sel, pc_sel;
  logic [2:0] state;
  logic [3:0] instret;

  core_ctrl_if mif ();

  core_ctrl #(.CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mif),
    .inst_type    (inst_type),
    .rd           (rd),
    .branch_taken (branch_taken),
    .ir_we        (ir_we),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .trap         (trap),
    .state        (state),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       full;
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       irwe;
    logic       a;
    logic       b;
    logic       regwe;
    logic [1:0] wbs;
    logic       pcwe;
    logic [1:0] pcs;
    logic       trp;
    logic [3:0] ret;
  } rec_t;

  typedef struct packed {
    logic       rstn;
    logic [3:0] ty;
    logic [4:0] rd;
    logic       tk;
    logic       ack;
  } drv_t;

  rec_t  exp_q[$];
  rec_t  bl_e[$];
  drv_t  bl_d[$];
  logic [3:0] cnt;
  int    errors = 0;
  int    checks = 0;
  string tag = "init";

  function automatic rec_t blank(input logic [2:0] st);
    rec_t r;
    r      = '0;
    r.full = 1'b1;
    r.st   = st;
    r.ret  = cnt;
    return r;
  endfunction

  function automatic drv_t mkd(input logic [3:0] ty, input logic [4:0] r,
                               input logic tk, input logic ack);
    drv_t d;
    d.rstn = 1'b1;
    d.ty   = ty;
    d.rd   = r;
    d.tk   = tk;
    d.ack  = ack;
    return d;
  endfunction

  function automatic drv_t rnd(input logic ack);
    return mkd(4'($urandom), 5'($urandom), 1'($urandom), ack);
  endfunction

  // Expected cycle trace of one instruction from the phase rules.
  task automatic build(input logic [3:0] ty, input logic [4:0] r,
                       input logic tk, input int fw, input int mw);
    rec_t e;
    bit   ld, st, br;
    ld = (ty == 0);
    st = (ty == 2);
    br = (ty == 6);
    for (int i = 0; i <= fw; i++) begin
      e = blank(3'd0);
      e.req  = 1'b1;
      e.irwe = (i == fw);
      bl_e.push_back(e);
      bl_d.push_back(rnd(i == fw));
    end
    bl_e.push_back(blank(3'd1));
    bl_d.push_back(mkd(ty, r, tk, 1'($urandom)));
    if (ty > 8) return;
    e   = blank(3'd2);
    e.a = (ty == 5 || ty == 8);
    e.b = !(ty == 3 || ty == 6);
    if (br) begin
      e.pcwe = 1'b1;
      e.pcs  = tk ? 2'd1 : 2'd0;
    end
    bl_e.push_back(e);
    bl_d.push_back(mkd(ty, r, tk, 1'($urandom)));
    if (br) begin
      cnt++;
      return;
    end
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        e = blank(3'd3);
        e.req  = 1'b1;
        e.asel = 1'b1;
        e.we   = st;
        e.pcwe = st && (i == mw);
        bl_e.push_back(e);
        bl_d.push_back(mkd(ty, r, tk, i == mw));
      end
      if (st) begin
        cnt++;
        return;
      end
    end
    e = blank(3'd4);
    e.regwe = (r != 0);
    e.pcwe  = 1'b1;
    case (ty)
      4'd0: e.wbs = 2'd1;
      4'd4: e.wbs = 2'd3;
      4'd7: e.wbs = 2'd2;
      4'd8: e.wbs = 2'd2;
      default: e.wbs = 2'd0;
    endcase
    e.pcs = (ty == 8) ? 2'd1 : (ty == 7) ? 2'd2 : 2'd0;
    bl_e.push_back(e);
    bl_d.push_back(mkd(ty, r, tk, 1'($urandom)));
    cnt++;
  endtask

  task automatic build_rst(input int n);
    drv_t d;
    for (int i = 0; i < n; i++) begin
      bl_e.push_back('0);
      d      = rnd(1'($urandom));
      d.rstn = 1'b0;
      bl_d.push_back(d);
    end
    cnt = '0;
  endtask

  task automatic build_trap(input int n);
    rec_t e;
    for (int i = 0; i < n; i++) begin
      e     = blank(3'd5);
      e.trp = 1'b1;
      bl_e.push_back(e);
      bl_d.push_back(rnd(1'($urandom)));
    end
  endtask

  // Plays up to cut cycles of the built trace; called just after a posedge.
  task automatic issue(input string t, input int cut);
    int n;
    tag = t;
    n   = (cut < bl_e.size()) ? cut : bl_e.size();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(bl_e[i]);
      rst_n          = bl_d[i].rstn;
      inst_type      = bl_d[i].ty;
      rd             = bl_d[i].rd;
      branch_taken   = bl_d[i].tk;
      mif.mem_ack    = bl_d[i].ack;
      @(posedge clk);
      #1;
    end
    bl_e.delete();
    bl_d.delete();
  endtask

  task automatic instr(input string t, input logic [3:0] ty,
                       input logic [4:0] r, input logic tk,
                       input int fw, input int mw);
    build(ty, r, tk, fw, mw);
    issue(t, 1000);
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  always @(negedge clk) begin
    rec_t e, g;
    bit   bad;
    if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      g.full  = e.full;
      g.st    = state;
      g.req   = mif.mem_req;
      g.we    = mif.mem_we;
      g.asel  = mif.addr_sel;
      g.irwe  = ir_we;
      g.a     = alu_a_sel;
      g.b     = alu_b_sel;
      g.regwe = reg_we;
      g.wbs   = wb_sel;
      g.pcwe  = pc_we;
      g.pcs   = pc_sel;
      g.trp   = trap;
      g.ret   = instret;
      if (e.full)
        bad = (g !== e);
      else
        bad = ({g.req, g.we, g.asel, g.irwe, g.regwe, g.pcwe, g.pcs, g.wbs}
               !== '0);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s t=%0t got %h exp %h", tag, $time, g, e);
      end
    end
  end

  initial begin
    logic [3:0] ty;
    logic [4:0] r;
    rst_n        = 1'b0;
    inst_type    = '0;
    rd           = '0;
    branch_taken = 1'b0;
    mif.mem_ack  = 1'b0;
    cnt          = '0;
    @(posedge clk);
    #1;
    build_rst(2);
    issue("reset", 1000);
    instr("rtype", 4'd3, 5'd5, 1'b0, 0, 0);
    instr("load_w2", 4'd0, 5'd7, 1'b0, 2, 2);
    instr("store", 4'd2, 5'd3, 1'b1, 0, 1);
    instr("br_taken", 4'd6, 5'd9, 1'b1, 0, 0);
    instr("br_not", 4'd6, 5'd9, 1'b0, 1, 0);
    instr("jal_rd1", 4'd8, 5'd1, 1'b0, 0, 0);
    instr("jalr_rd0", 4'd7, 5'd0, 1'b1, 0, 0);
    instr("lui_rd0", 4'd4, 5'd0, 1'b0, 0, 0);
    instr("auipc", 4'd5, 5'd31, 1'b0, 0, 0);
    instr("imm", 4'd1, 5'd2, 1'b0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      ty = 4'($urandom_range(0, 8));
      r  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      instr("random", ty, r, 1'($urandom), $urandom_range(0, 2),
            $urandom_range(0, 2));
    end
    build(4'd0, 5'd7, 1'b0, 0, 4);
    issue("ld_abort", 5);
    build_rst(1);
    issue("rst_mid_mem", 1000);
    instr("after_rst", 4'd0, 5'd7, 1'b0, 0, 0);
    build(4'd12, 5'd4, 1'b0, 1, 0);
    build_trap(20);
    issue("illegal", 1000);
    build_rst(1);
    issue("trap_rst", 1000);
    instr("post_trap", 4'd3, 5'd1, 1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
